// File: rtl/result_sel_arbiter_if.sv
// Bus bundle between the result-select arbiter and its environment:
// the four request/ack lines, the mux data coming back, and the
// captured result and overflow statistics going out.
interface result_sel_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       req;      // level request, bit i owns mux input y(i+1)
  logic             ovf_clr;  // synchronous clear of the overflow counter
  logic [WIDTH-1:0] mux_out;  // data returned by the 4:1 result mux
  logic             mux_ovf;  // overflow bit returned by the mux
  logic [1:0]       sel;      // mux select (binary index of the grant)
  logic [3:0]       ack;      // one-hot completion pulse
  logic [WIDTH-1:0] result;   // captured result of the last transaction
  logic             ovf_out;  // captured overflow of the last transaction
  logic             busy;     // arbiter is not idle
  logic [7:0]       ovf_cnt;  // saturating count of overflowed captures

  // Arbiter side.
  modport slave (
    input  req, ovf_clr, mux_out, mux_ovf,
    output sel, ack, result, ovf_out, busy, ovf_cnt
  );

  // Requester / datapath side.
  modport master (
    output req, ovf_clr, mux_out, mux_ovf,
    input  sel, ack, result, ovf_out, busy, ovf_cnt
  );
endinterface

// File: rtl/result_sel_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 result mux of the
// calculator datapath. A granted requester gets the mux select, the
// arbiter waits SETTLE cycles for the mux output to settle, captures
// result and overflow, and pulses a one-hot ack back to the winner.
// A saturating counter tracks how many captured results overflowed.
module result_sel_arbiter #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  result_sel_arbiter_if.slave  bus
);

  // A programmed settle of 0 is treated as 1; the counter is 4 bits wide.
  localparam logic [3:0] SETTLE_EFF = (SETTLE < 1)  ? 4'd1  :
                                      (SETTLE > 15) ? 4'd15 :
                                      4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [1:0]       r_sel;         // current mux select, also the winner
  logic [1:0]       r_last_grant;  // most recently completed requester
  logic [3:0]       r_cnt;         // settle countdown
  logic [3:0]       r_ack;
  logic [WIDTH-1:0] r_result;
  logic             r_ovf_out;
  logic             r_busy;
  logic [7:0]       r_ovf_cnt;

  logic             w_req_any;
  logic             w_found;
  logic [1:0]       w_winner;
  logic             w_grant;       // IDLE -> WAIT on this edge
  logic             w_capture;     // WAIT -> ACK on this edge

  // Round-robin pick: scan upward from the requester after the last
  // grant, wrapping, so the last winner has the lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    w_req_any = |bus.req;
    w_found   = 1'b0;
    w_winner  = r_last_grant + 2'd1;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && bus.req[2'(r_last_grant + 2'(i))]) begin
        w_found  = 1'b1;
        w_winner = 2'(r_last_grant + 2'(i));
      end
    end
  end

  // FSM next-state and transition strobes.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_state_next = ST_WAIT;
          w_grant      = 1'b1;
        end
      end
      ST_WAIT: begin
        // Capture when the countdown reaches 1; the <= also guards an
        // out-of-range 0 so the FSM can never stall in WAIT.
        if (r_cnt <= 4'd1) begin
          w_state_next = ST_ACK;
          w_capture    = 1'b1;
        end
      end
      ST_ACK: begin
        // Requests are not sampled here; arbitration resumes in IDLE.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant bookkeeping: select, settle countdown and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= 2'd0;
      r_cnt        <= 4'd0;
      r_last_grant <= 2'd3;  // req[0] wins first after reset
    end else begin
      if (w_grant) begin
        r_sel <= w_winner;
        r_cnt <= SETTLE_EFF;
      end else if (r_state == ST_WAIT && !w_capture) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_last_grant <= r_sel;
      end
    end
  end

  // Result capture, ack pulse and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_ovf_out <= 1'b0;
      r_ack     <= 4'b0000;
      r_busy    <= 1'b0;
    end else begin
      // ACK lasts one cycle, so the pulse is simply the capture strobe
      // delayed into the register.
      r_ack  <= w_capture ? (4'b0001 << r_sel) : 4'b0000;
      r_busy <= (w_state_next != ST_IDLE);
      if (w_capture) begin
        r_result  <= bus.mux_out;
        r_ovf_out <= bus.mux_ovf;
      end
    end
  end

  // Saturating overflow counter; a clear wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= 8'd0;
    end else if (bus.ovf_clr) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_capture && bus.mux_ovf && r_ovf_cnt != 8'hFF) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.ack     = r_ack;
  assign bus.result  = r_result;
  assign bus.ovf_out = r_ovf_out;
  assign bus.busy    = r_busy;
  assign bus.ovf_cnt = r_ovf_cnt;

endmodule
